// File: rtl/data_mem_waitctrl.sv
// Wait-state controller between the core data port and a slow synchronous data RAM.
// Each access is latched, held on the RAM side for WAIT_CYCLES+1 cycles, and the core is stalled meanwhile.
module data_mem_waitctrl #(
  parameter int WAIT_CYCLES = 2,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_ce_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [3:0]  cpu_sel_i,
  input  logic [31:0] cpu_data_i,
  output logic [31:0] cpu_data_o,
  output logic        stall_req_o,
  output logic        ram_ce_o,
  output logic        ram_we_o,
  output logic [31:0] ram_addr_o,
  output logic [3:0]  ram_sel_o,
  output logic [31:0] ram_data_o,
  input  logic [31:0] ram_data_i,
  output logic [1:0]  dbg_state
);

  // Handshake: the core raises cpu_ce_i and holds the access stable while stall_req_o
  // is high; the access completes in the first cycle with cpu_ce_i=1 and stall_req_o=0.

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [3:0]       sel_q;
  logic [31:0]      data_q;
  logic             final_cycle;

  assign final_cycle = (cnt == '0);
  assign dbg_state   = state;
  assign ram_addr_o  = addr_q;
  assign ram_sel_o   = sel_q;
  assign ram_data_o  = data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // DONE always returns to IDLE so the just-completed request is never restarted.
  always_comb begin
    state_nxt   = state;
    stall_req_o = 1'b0;
    ram_ce_o    = 1'b0;
    ram_we_o    = 1'b0;
    case (state)
      IDLE: begin
        stall_req_o = cpu_ce_i & rst;
        if (cpu_ce_i) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        stall_req_o = 1'b1;
        ram_ce_o    = 1'b1;
        ram_we_o    = we_q & final_cycle;
        if (final_cycle) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt        <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      sel_q      <= '0;
      data_q     <= '0;
      cpu_data_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_ce_i) begin
            we_q   <= cpu_we_i;
            addr_q <= cpu_addr_i;
            sel_q  <= cpu_sel_i;
            data_q <= cpu_data_i;
            cnt    <= CNT_W'(WAIT_CYCLES);
          end
        end
        ACCESS: begin
          if (final_cycle) begin
            if (!we_q) begin
              cpu_data_o <= ram_data_i;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
